// File: rtl/drygascon128_apb3_seq.sv
// drygascon128_apb3_seq: turns a command stream into APB3 master transfers to a
// DryGASCON128 core. START is followed by ctrl polling until the done bit is seen.
// Ports: toplevel_io_mainClk/toplevel_resetCtrl_systemReset (sync, active-high),
//   cmd_* (valid/ready command in), rsp_* (valid/ready read word out),
//   io_apb_* (APB3 master), busy (not idle), err (sticky slave/op error).
// Optional: define DRYGASCON128_APB3_SEQ_TIMEOUT_EN to bound polling at
//   TIMEOUT_POLLS ctrl reads per START.
module drygascon128_apb3_seq #(
    parameter int TIMEOUT_POLLS = 1024
) (
    input  logic        toplevel_io_mainClk,
    input  logic        toplevel_resetCtrl_systemReset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [7:0]  io_apb_PADDR,
    output logic        io_apb_PSEL,
    output logic        io_apb_PENABLE,
    output logic        io_apb_PWRITE,
    output logic [31:0] io_apb_PWDATA,
    input  logic [31:0] io_apb_PRDATA,
    input  logic        io_apb_PREADY,
    input  logic        io_apb_PSLVERROR,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP, GAP} state_t;
    typedef enum logic [1:0] {K_WR, K_RD, K_START, K_POLL} kind_t;

    state_t      state;
    kind_t       kind;
    logic        gap;

    logic        req_ok;
    logic        req_wr;
    logic [7:0]  req_addr;
    logic [31:0] req_data;
    kind_t       req_kind;

`ifdef DRYGASCON128_APB3_SEQ_TIMEOUT_EN
    localparam int PW = $clog2(TIMEOUT_POLLS + 1);
    logic [PW-1:0] poll_cnt;
`else
    localparam int unused_timeout_polls = TIMEOUT_POLLS;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        req_ok   = 1'b1;
        req_wr   = 1'b0;
        req_addr = 8'h00;
        req_data = 32'h0;
        req_kind = K_WR;
        case (cmd_op)
            3'd0: begin req_wr = 1'b1; req_addr = 8'h04; req_data = cmd_data; end
            3'd1: begin req_wr = 1'b1; req_addr = 8'h0C; req_data = cmd_data; end
            3'd2: begin req_wr = 1'b1; req_addr = 8'h08; req_data = cmd_data; end
            3'd3: begin
                req_wr   = 1'b1;
                req_data = {23'b0, 1'b1, cmd_data[7:0]};
                req_kind = K_START;
            end
            3'd4: begin req_addr = 8'h08; req_kind = K_RD; end
            3'd5: begin req_addr = 8'h04; req_kind = K_RD; end
            default: req_ok = 1'b0;
        endcase
    end

    always_ff @(posedge toplevel_io_mainClk) begin
        if (toplevel_resetCtrl_systemReset) begin
            state          <= IDLE;
            kind           <= K_WR;
            gap            <= 1'b0;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= 32'h0;
            err            <= 1'b0;
            io_apb_PSEL    <= 1'b0;
            io_apb_PENABLE <= 1'b0;
            io_apb_PWRITE  <= 1'b0;
            io_apb_PADDR   <= 8'h00;
            io_apb_PWDATA  <= 32'h0;
`ifdef DRYGASCON128_APB3_SEQ_TIMEOUT_EN
            poll_cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        if (req_ok) begin
                            cmd_ready     <= 1'b0;
                            state         <= SETUP;
                            kind          <= req_kind;
                            io_apb_PSEL   <= 1'b1;
                            io_apb_PWRITE <= req_wr;
                            io_apb_PADDR  <= req_addr;
                            io_apb_PWDATA <= req_data;
                        end else begin
                            err <= 1'b1;
                        end
                    end else begin
                        cmd_ready <= ~rsp_valid;
                    end
                end
                SETUP: begin
                    io_apb_PENABLE <= 1'b1;
                    state          <= ACCESS;
                end
                ACCESS: begin
                    if (io_apb_PREADY) begin
                        if (io_apb_PSLVERROR) err <= 1'b1;
                        io_apb_PSEL    <= 1'b0;
                        io_apb_PENABLE <= 1'b0;
                        io_apb_PWRITE  <= 1'b0;
                        io_apb_PADDR   <= 8'h00;
                        io_apb_PWDATA  <= 32'h0;
                        case (kind)
                            K_WR: begin
                                state     <= IDLE;
                                cmd_ready <= 1'b1;
                            end
                            K_RD: begin
                                state     <= RESP;
                                rsp_valid <= 1'b1;
                                rsp_data  <= io_apb_PRDATA;
                            end
                            K_START: begin
                                state <= GAP;
                                gap   <= 1'b0;
`ifdef DRYGASCON128_APB3_SEQ_TIMEOUT_EN
                                poll_cnt <= '0;
`endif
                            end
                            default: begin
                                if (io_apb_PRDATA[31]) begin
                                    state     <= IDLE;
                                    cmd_ready <= 1'b1;
`ifdef DRYGASCON128_APB3_SEQ_TIMEOUT_EN
                                end else if (poll_cnt == PW'(TIMEOUT_POLLS - 1)) begin
                                    err       <= 1'b1;
                                    state     <= IDLE;
                                    cmd_ready <= 1'b1;
                                end else begin
                                    poll_cnt    <= poll_cnt + 1'b1;
                                    state       <= SETUP;
                                    io_apb_PSEL <= 1'b1;
`else
                                end else begin
                                    // back-to-back poll: next SETUP follows directly
                                    state       <= SETUP;
                                    io_apb_PSEL <= 1'b1;
`endif
                                end
                            end
                        endcase
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap) begin
                        state       <= SETUP;
                        kind        <= K_POLL;
                        io_apb_PSEL <= 1'b1;
                    end else begin
                        gap <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_drygascon128_apb3_seq.sv
// tb_drygascon128_apb3_seq: scoreboard bench for drygascon128_apb3_seq with a
// behavioural APB3 slave (wait states, slave error, read-data queue).
module tb_drygascon128_apb3_seq;

`ifdef DRYGASCON128_APB3_SEQ_TIMEOUT_EN
    localparam int TP = 4;
`else
    localparam int TP = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [31:0] cmd_data = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic [7:0]  paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata = 32'h0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;
    logic        busy, err;

    always #5 clk = ~clk;

    drygascon128_apb3_seq #(.TIMEOUT_POLLS(TP)) dut (
        .toplevel_io_mainClk(clk),
        .toplevel_resetCtrl_systemReset(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .io_apb_PADDR(paddr),
        .io_apb_PSEL(psel),
        .io_apb_PENABLE(penable),
        .io_apb_PWRITE(pwrite),
        .io_apb_PWDATA(pwdata),
        .io_apb_PRDATA(prdata),
        .io_apb_PREADY(pready),
        .io_apb_PSLVERROR(pslverr),
        .busy(busy),
        .err(err)
    );

    typedef struct packed {
        logic [7:0]  a;
        logic        w;
        logic [31:0] d;
    } apb_t;

    apb_t        exp_q[$];
    logic [31:0] rsp_q[$];
    logic [31:0] sd_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          wait_n = 0;
    int          wcnt = 0;
    logic        slverr = 1'b0;
    bit          mon_en = 1'b0;
    int          setups = 0;
    int          gaps = 0;
    apb_t        cur;
    logic [7:0]  hold_a;
    logic        hold_w;
    logic [31:0] hold_d;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_apb(input logic [7:0] a, input logic w,
                            input logic [31:0] d);
        apb_t e;
        e.a = a; e.w = w; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("cmd_ready_tmo", 32'(cmd_ready), 1);
        cmd_op = op;
        cmd_data = d;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(busy), 0);
    endtask

    // APB slave: responds at negedge so PREADY is stable at the next posedge
    always @(negedge clk) begin
        if (psel && penable) begin
            if (wcnt >= wait_n) begin
                pready = 1'b1;
                pslverr = slverr;
                prdata = 32'h0;
                if (!pwrite && sd_q.size() != 0) prdata = sd_q.pop_front();
            end else begin
                pready = 1'b0;
                wcnt++;
            end
        end else begin
            pready = 1'b0;
            pslverr = 1'b0;
            wcnt = 0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (busy && !psel) gaps++;
            if (psel && !penable) begin
                setups++;
                chk("apb_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    chk("paddr", 32'(paddr), 32'(cur.a));
                    chk("pwrite", 32'(pwrite), 32'(cur.w));
                    if (cur.w) chk("pwdata", pwdata, cur.d);
                end
                hold_a = paddr;
                hold_w = pwrite;
                hold_d = pwdata;
            end else if (psel && penable) begin
                chk("hold_addr", 32'(paddr), 32'(hold_a));
                chk("hold_write", 32'(pwrite), 32'(hold_w));
                chk("hold_wdata", pwdata, hold_d);
            end else begin
                chk("idle_penable", 32'(penable), 0);
                chk("idle_paddr", 32'(paddr), 0);
                chk("idle_pwdata", pwdata, 0);
            end
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", 32'(rsp_q.size() != 0), 1);
                if (rsp_q.size() != 0) chk("rsp_data", rsp_data, rsp_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n;
        @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_psel", 32'(psel), 0);
        chk("rst_pwrite", 32'(pwrite), 0);
        mon_en = 1'b1;
        #1 rst = 1'b0;

        // WR_C timing with zero-wait slave
        push_apb(8'h04, 1'b1, 32'h01234567);
        do_cmd(3'd0, 32'h01234567);
        @(negedge clk);
        chk("wr_setup_psel", 32'(psel), 1);
        chk("wr_setup_pen", 32'(penable), 0);
        chk("wr_setup_ready", 32'(cmd_ready), 0);
        @(negedge clk);
        chk("wr_access_pen", 32'(penable), 1);
        chk("wr_access_ready", 32'(cmd_ready), 0);
        @(negedge clk);
        chk("wr_ready_3cyc", 32'(cmd_ready), 1);
        chk("wr_busy_done", 32'(busy), 0);

        // RD_R with stalled response
        push_apb(8'h08, 1'b0, 32'h0);
        sd_q.push_back(32'hDEADBEEF);
        rsp_q.push_back(32'hDEADBEEF);
        rsp_ready = 1'b0;
        do_cmd(3'd4, 32'h0);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("rd_rsp_valid", 32'(rsp_valid), 1);
            chk("rd_rsp_hold", rsp_data, 32'hDEADBEEF);
            chk("rd_cmd_ready", 32'(cmd_ready), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_idle("rd_done");

        // START with three not-done polls
        push_apb(8'h00, 1'b1, 32'h0000011B);
        for (int i = 0; i < 4; i++) push_apb(8'h00, 1'b0, 32'h0);
        sd_q.push_back(32'h0);
        sd_q.push_back(32'h0);
        sd_q.push_back(32'h0);
        sd_q.push_back(32'h8000001B);
        setups = 0;
        gaps = 0;
        do_cmd(3'd3, 32'h0000001B);
        wait_idle("start_done");
        chk("start_setups", setups, 5);
        chk("start_gap", gaps, 2);
        chk("start_err", 32'(err), 0);

        // write with wait states and slave error
        wait_n = 3;
        slverr = 1'b1;
        push_apb(8'h0C, 1'b1, 32'hA5A5A5A5);
        do_cmd(3'd1, 32'hA5A5A5A5);
        wait_idle("slverr_done");
        chk("slverr_err", 32'(err), 1);
        wait_n = 0;
        slverr = 1'b0;

        // RD_C after error: data still returned, err sticky
        push_apb(8'h04, 1'b0, 32'h0);
        sd_q.push_back(32'h13579BDF);
        rsp_q.push_back(32'h13579BDF);
        do_cmd(3'd5, 32'h0);
        wait_idle("rdc_done");
        chk("err_sticky", 32'(err), 1);

        // reset during ACCESS of RD_C
        wait_n = 20;
        push_apb(8'h04, 1'b0, 32'h0);
        do_cmd(3'd5, 32'h0);
        n = 0;
        @(negedge clk);
        while (!penable && n < 50) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_psel", 32'(psel), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_rst_err", 32'(err), 0);
        rst = 1'b0;
        wait_n = 0;

        // reserved op: no transfer, err set
        setups = 0;
        do_cmd(3'd6, 32'h0);
        @(negedge clk);
        chk("rsv_err", 32'(err), 1);
        chk("rsv_busy", 32'(busy), 0);
        chk("rsv_setups", setups, 0);

`ifdef DRYGASCON128_APB3_SEQ_TIMEOUT_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push_apb(8'h00, 1'b1, 32'h00000107);
        for (int i = 0; i < 4; i++) push_apb(8'h00, 1'b0, 32'h0);
        setups = 0;
        do_cmd(3'd3, 32'hFFFFFE07);
        wait_idle("tmo_done");
        chk("tmo_setups", setups, 5);
        chk("tmo_err", 32'(err), 1);
`endif

        repeat (3) @(negedge clk);
        chk("apb_q_left", exp_q.size(), 0);
        chk("rsp_q_left", rsp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
